lian_game_ctrl: RTL
===================

// Module: lian_game_ctrl
// PURPOSE
// Parametrised game controller for the lianliankan board: one block owning
// cursor movement, two-card selection, card-ID fetch from the board ROM,
// match decision, blink timing, hidden-card tracking and win detection.
// Sits between the debounced input module and vga_timing/board in top.
// Generalises board size to ROWS x COLS; adds wrap-around cursor, pair
// counter and sticky win flag.
// PARAMETERS
// ROWS       6           board rows
// COLS       6           board columns; N = ROWS*COLS, must be even
// ADDR_W     6           card address width, >= clog2(N)
// CARD_W     8           card ID width (board ROM r,g,b concatenated)
// BLINK_CYC  50_000_000  cycles both selected cards blink after a decision
// PORTS
// clk          in   1       system clock (100 MHz)
// rst          in   1       synchronous, active-low reset
// up/down/left/right in 1   single-cycle debounced move pulses
// s            in   1       single-cycle debounced select pulse
// card_addr    out  ADDR_W  board ROM address
// card_id      in   CARD_W  board ROM data, valid 1 cycle after card_addr
// cur_bus      out  N       one-hot cursor position
// sel_bus      out  N       selected cards (0..2 bits set)
// blink_bus    out  N       cards currently blinking
// hidden_bus   out  N       matched (removed) cards
// ms / mf      out  1       match success / fail, one-cycle pulses
// en_input     out  1       high when selections are accepted
// pairs_left   out  ADDR_W  pairs still on board
// win          out  1       sticky: all pairs removed
// BEHAVIOUR
// Reset (rst==0 at posedge, any state): cursor idx 0 (cur_bus=1), sel/blink/
//  hidden=0, ms=mf=0, en_input=1, pairs_left=N/2, win=0, timer=0, IDLE.
// Cursor (every state except DONE): one move/cycle, priority up>down>left>
//  right. up: row-1, row 0 -> ROWS-1; down: ROWS-1 -> 0; left/right wrap
//  within the current row. Cursor may rest on hidden cards.
// Select: accepted only in IDLE with en_input=1; uses the pre-move cursor
//  idx if a move pulse coincides. Ignored if card hidden or already selected.
//  First accept: set sel bit, idx0. Second: set sel bit, idx1, en_input<=0,
//  -> FETCH0.
// FSM: IDLE -> FETCH0 (card_addr=idx0) -> FETCH1 (card_addr=idx1, latch id0)
//  -> FETCH2 (latch id1) -> CMP (ms=id0==id1, else mf; one cycle)
//  -> SHOW (blink_bus=sel_bus, timer counts to BLINK_CYC-1)
//  -> RESOLVE (match: hidden|=sel, pairs_left-1; always sel=0, blink=0,
//  en_input=1) -> IDLE, or -> DONE if pairs_left becomes 0.
// Latency: second s accepted at edge T -> ms/mf high in cycle T+3..T+4,
//  RESOLVE BLINK_CYC cycles after CMP.
// card_addr = cursor idx in IDLE/SHOW/RESOLVE/DONE.
// DONE: win=1, en_input=0, all inputs ignored until reset.
// Mismatch: hidden_bus and pairs_left unchanged. Timer width
//  clog2(BLINK_CYC+1); pairs_left never underflows.
// TESTING
// Reset then 6 right pulses (6x6) -> cur_bus bit0 (row wrap); 1 up -> bit30.
// Select idx0,idx1 with equal ROM IDs -> ms pulse 1 cycle, blink_bus=0x3 for
//  BLINK_CYC, then hidden_bus=0x3, pairs_left=17, en_input=1.
// Select idx0,idx2 with different IDs -> mf pulse, hidden_bus stays 0,
//  sel_bus=0 after blink.
// s on hidden card, s twice on same card, s while en_input=0 -> ignored.
// BLINK_CYC=4, ROWS=2, COLS=2: clear both pairs -> win=1, en_input=0, sticky.
// rst=0 during SHOW -> next edge all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/lian_game_ctrl_if.sv
// lianliankan game controller bundle: move/select pulses, board ROM
// port and board status buses between input logic, controller and video.
interface lian_game_ctrl_if #(
  parameter int N      = 36,
  parameter int ADDR_W = 6,
  parameter int CARD_W = 8
);
  logic              up;
  logic              down;
  logic              left;
  logic              right;
  logic              s;
  logic [ADDR_W-1:0] card_addr;
  logic [CARD_W-1:0] card_id;
  logic [N-1:0]      cur_bus;
  logic [N-1:0]      sel_bus;
  logic [N-1:0]      blink_bus;
  logic [N-1:0]      hidden_bus;
  logic              ms;
  logic              mf;
  logic              en_input;
  logic [ADDR_W-1:0] pairs_left;
  logic              win;

  modport master (
    input  up, down, left, right, s, card_id,
    output card_addr, cur_bus, sel_bus, blink_bus, hidden_bus,
    output ms, mf, en_input, pairs_left, win
  );

  modport slave (
    output up, down, left, right, s, card_id,
    input  card_addr, cur_bus, sel_bus, blink_bus, hidden_bus,
    input  ms, mf, en_input, pairs_left, win
  );
endinterface

// File: rtl/lian_game_ctrl.sv
// lianliankan game controller: cursor, two-card selection, ROM fetch,
// match decision, blink timing, hidden-card tracking and win detection.
module lian_game_ctrl #(
  parameter int ROWS      = 6,
  parameter int COLS      = 6,
  parameter int ADDR_W    = 6,
  parameter int CARD_W    = 8,
  parameter int BLINK_CYC = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  lian_game_ctrl_if.master io
);
  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = $clog2(BLINK_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH1, FETCH2, CMP, SHOW, RESOLVE, DONE
  } state_t;

  state_t            state;
  logic [RW-1:0]     row, row_n;
  logic [CW-1:0]     col, col_n;
  logic [ADDR_W-1:0] idx, idx0, idx1, pairs;
  logic [N-1:0]      cur, sel, blink, hidden;
  logic [CARD_W-1:0] id0;
  logic [TW-1:0]     timer;
  logic              ms, mf, en, win, match, pick;

  assign idx = ADDR_W'(int'(row) * COLS + int'(col));
  assign cur = N'(1) << idx;

  // select always uses the cursor as it was before any coincident move
  assign pick = io.s && en && (state == IDLE)
              && ((cur & (hidden | sel)) == '0);

  always_comb begin
    row_n = row;
    col_n = col;
    priority case (1'b1)
      io.up:
        row_n = (row == '0) ? RW'(ROWS - 1) : row - 1'b1;
      io.down:
        row_n = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
      io.left:
        col_n = (col == '0) ? CW'(COLS - 1) : col - 1'b1;
      io.right:
        col_n = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    unique case (state)
      FETCH0:              io.card_addr = idx0;
      FETCH1, FETCH2, CMP: io.card_addr = idx1;
      default:             io.card_addr = idx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      sel    <= '0;
      blink  <= '0;
      hidden <= '0;
      ms     <= 1'b0;
      mf     <= 1'b0;
      en     <= 1'b1;
      pairs  <= ADDR_W'(N / 2);
      win    <= 1'b0;
      timer  <= '0;
      idx0   <= '0;
      idx1   <= '0;
      id0    <= '0;
      match  <= 1'b0;
    end else begin
      if (state != DONE) begin
        row <= row_n;
        col <= col_n;
      end
      ms <= 1'b0;
      mf <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick) begin
            sel <= sel | cur;
            if (sel == '0) begin
              idx0 <= idx;
            end else begin
              idx1  <= idx;
              en    <= 1'b0;
              state <= FETCH0;
            end
          end
        end
        FETCH0: state <= FETCH1;
        FETCH1: begin
          id0   <= io.card_id;
          state <= FETCH2;
        end
        // second ID arrives now; decide so the pulse lands in CMP
        FETCH2: begin
          match <= (id0 == io.card_id);
          ms    <= (id0 == io.card_id);
          mf    <= (id0 != io.card_id);
          state <= CMP;
        end
        CMP: begin
          blink <= sel;
          timer <= '0;
          state <= SHOW;
        end
        SHOW: begin
          if (timer == TW'(BLINK_CYC - 1)) begin
            blink <= '0;
            timer <= '0;
            state <= RESOLVE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESOLVE: begin
          sel <= '0;
          if (match && pairs != '0) begin
            hidden <= hidden | sel;
            pairs  <= pairs - 1'b1;
          end
          if (match && pairs == ADDR_W'(1)) begin
            win   <= 1'b1;
            en    <= 1'b0;
            state <= DONE;
          end else begin
            en    <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign io.sel_bus    = sel;
  assign io.blink_bus  = blink;
  assign io.hidden_bus = hidden;
  assign io.cur_bus    = cur;
  assign io.ms         = ms;
  assign io.mf         = mf;
  assign io.en_input   = en;
  assign io.pairs_left = pairs;
  assign io.win        = win;
endmodule
